fp_add_normalize: RTL and testbench

FP_ADD_NORMALIZE -- requirements
Module: fp_add_normalize

---
 rtl/fp_add_normalize.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_add_normalize.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// ---------------------------------------------------------------------------
// fp_add_normalize
//
// Add/subtract-and-normalize stage of a floating-point adder. Takes two
// mantissas already aligned to a common exponent, forms the signed sum,
// normalizes it one bit per cycle and hands the result to the rounding stage.
//
// Mantissa layout (MW = 26): [25] hidden, [24:2] fraction, [1] guard,
// [0] round/sticky. The internal sum is one bit wider to hold the carry.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand-set handshake
//   signA, signB               operand signs
//   exponentIn                 common exponent from the alignment stage
//   alignedMantissaA/B         aligned mantissas
//   out_valid / out_ready      result handshake
//   out_sign, out_exponent,
//   out_mantissa               registered result (same layout as inputs)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, so one operand set is in flight at a
// time. out_valid is 1 only in DONE, where the result is held stable until
// out_ready is seen; the stage then returns to IDLE on that edge.
//
// Special operands: when exponentIn is all ones, an operand whose hidden bit
// is clear is taken to carry the all-ones exponent field (infinity or NaN);
// an operand with the hidden bit set is a finite value aligned to it.
// ---------------------------------------------------------------------------
module fp_add_normalize #(
  parameter int MW = 26,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          signA,
  input  logic          signB,
  input  logic [EW-1:0] exponentIn,
  input  logic [MW-1:0] alignedMantissaA,
  input  logic [MW-1:0] alignedMantissaB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exponent,
  output logic [MW-1:0] out_mantissa
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [EW-1:0] EXP_MAX     = '1;
  localparam logic [EW-1:0] EXP_ONE     = EW'(1);
  localparam logic [EW-1:0] EXP_PRE_MAX = EXP_MAX - EXP_ONE;
  localparam logic [MW-1:0] HIDDEN      = MW'(1) << (MW - 1);
  localparam logic [MW-1:0] QNAN        = MW'(1) << (MW - 2);

  state_t        state_q, state_d;

  // Captured operand set
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [EW-1:0] exp_in_q, exp_in_d;
  logic [MW-1:0] mant_a_q, mant_a_d;
  logic [MW-1:0] mant_b_q, mant_b_d;

  // Working sum, exponent and sign during normalization
  logic [MW:0]   sum_q, sum_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          sign_q, sign_d;

  // Registered result
  logic          out_sign_q, out_sign_d;
  logic [EW-1:0] out_exp_q, out_exp_d;
  logic [MW-1:0] out_mant_q, out_mant_d;

  // Combinational helpers for the ADD state
  logic [MW:0]   add_sum;
  logic          add_sign;
  logic [EW-1:0] add_exp;
  logic          a_special, b_special;
  logic          a_frac_zero, b_frac_zero;

  always_comb begin
    add_sum     = '0;
    add_sign    = 1'b0;
    add_exp     = (exp_in_q == '0) ? EXP_ONE : exp_in_q;
    a_special   = ~mant_a_q[MW-1];
    b_special   = ~mant_b_q[MW-1];
    a_frac_zero = (mant_a_q[MW-2:0] == '0);
    b_frac_zero = (mant_b_q[MW-2:0] == '0);

    // Sign-magnitude add: for unlike signs subtract the smaller magnitude
    // from the larger so the sum is never negative.
    if (sign_a_q == sign_b_q) begin
      add_sum  = {1'b0, mant_a_q} + {1'b0, mant_b_q};
      add_sign = sign_a_q;
    end else if (mant_a_q >= mant_b_q) begin
      add_sum  = {1'b0, mant_a_q} - {1'b0, mant_b_q};
      add_sign = sign_a_q;
    end else begin
      add_sum  = {1'b0, mant_b_q} - {1'b0, mant_a_q};
      add_sign = sign_b_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    exp_in_d   = exp_in_q;
    mant_a_d   = mant_a_q;
    mant_b_d   = mant_b_q;
    sum_d      = sum_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_mant_d = out_mant_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_a_d = signA;
          sign_b_d = signB;
          exp_in_d = exponentIn;
          mant_a_d = alignedMantissaA;
          mant_b_d = alignedMantissaB;
          state_d  = ADD;
        end
      end

      ADD: begin
        if (exp_in_q == EXP_MAX) begin
          out_exp_d = EXP_MAX;
          if (a_frac_zero && b_frac_zero && (sign_a_q != sign_b_q) &&
              a_special && b_special) begin
            // +inf + -inf
            out_mant_d = QNAN;
            out_sign_d = 1'b0;
          end else begin
            out_mant_d = (mant_a_q | mant_b_q) & ~HIDDEN;
            out_sign_d = (b_special && !a_special) ? sign_b_q : sign_a_q;
          end
          state_d = DONE;
        end else if (add_sum == '0) begin
          // Exact cancellation yields +0
          out_sign_d = 1'b0;
          out_exp_d  = '0;
          out_mant_d = '0;
          state_d    = DONE;
        end else begin
          sum_d   = add_sum;
          exp_d   = add_exp;
          sign_d  = add_sign;
          state_d = NORM;
        end
      end

      NORM: begin
        if (sum_q[MW]) begin
          if (exp_q == EXP_PRE_MAX) begin
            // Carry-out would push the exponent to all ones: infinity
            out_sign_d = sign_q;
            out_exp_d  = EXP_MAX;
            out_mant_d = '0;
            state_d    = DONE;
          end else begin
            // Keep the dropped bit alive in the sticky position
            sum_d = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
            exp_d = exp_q + EXP_ONE;
          end
        end else if (!sum_q[MW-1] && (exp_q > EXP_ONE)) begin
          sum_d = {sum_q[MW-1:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
        end else begin
          // A clear hidden bit here means the result stayed subnormal
          out_sign_d = sign_q;
          out_exp_d  = sum_q[MW-1] ? exp_q : '0;
          out_mant_d = sum_q[MW-1:0];
          state_d    = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      exp_in_q   <= '0;
      mant_a_q   <= '0;
      mant_b_q   <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_mant_q <= '0;
    end else begin
      state_q    <= state_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      exp_in_q   <= exp_in_d;
      mant_a_q   <= mant_a_d;
      mant_b_q   <= mant_b_d;
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_mant_q <= out_mant_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_sign     = out_sign_q;
  assign out_exponent = out_exp_q;
  assign out_mantissa = out_mant_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// ---------------------------------------------------------------------------
// Bench for fp_add_normalize: directed vectors with hand-computed results,
// randomized operand sets checked against an arithmetic reference model,
// backpressure hold and an asynchronous reset during normalization.
// Latency is counted in rising edges from the edge after which in_valid is
// driven (edge N); the operand set is taken on edge N+1.
// ---------------------------------------------------------------------------
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_a, sign_b;
  logic [7:0]  exp_in;
  logic [25:0] mant_a, mant_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [25:0] out_mantissa;

  int tests_run    = 0;
  int tests_failed = 0;

  fp_add_normalize dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .signA            (sign_a),
    .signB            (sign_b),
    .exponentIn       (exp_in),
    .alignedMantissaA (mant_a),
    .alignedMantissaB (mant_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sign         (out_sign),
    .out_exponent     (out_exponent),
    .out_mantissa     (out_mantissa)
  );

  // ---- clock ---------------------------------------------------------------
  always #5 clk = ~clk;

  // ---- checking ------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  // Plain integer arithmetic: normalized result = sum scaled so that its
  // leading one sits at bit 25, limited by the minimum exponent of 1.
  function automatic void model(input logic [7:0] ei, input logic [25:0] a,
                                input logic [25:0] b, input logic sa,
                                input logic sb, output logic xs,
                                output logic [7:0] xe, output logic [25:0] xm,
                                output int xl);
    longint s;
    int     e;
    int     p;
    int     k;
    bit     a_sp, b_sp;
    if (ei == 8'd255) begin
      a_sp = (a[25] == 1'b0);
      b_sp = (b[25] == 1'b0);
      xe = 8'd255;
      xl = 2;
      if (a[24:0] == 0 && b[24:0] == 0 && sa != sb && a_sp && b_sp) begin
        xm = 26'h1000000;
        xs = 1'b0;
      end else begin
        xm = (a | b) & 26'h1FFFFFF;
        xs = (b_sp && !a_sp) ? sb : sa;
      end
      return;
    end
    e = (ei == 0) ? 1 : int'(ei);
    if (sa == sb) begin
      s = longint'(a) + longint'(b); xs = sa;
    end else if (a >= b) begin
      s = longint'(a) - longint'(b); xs = sa;
    end else begin
      s = longint'(b) - longint'(a); xs = sb;
    end
    if (s == 0) begin
      xs = 1'b0; xe = 8'd0; xm = 26'd0; xl = 2;
      return;
    end
    if (s >= (64'd1 << 26)) begin
      if (e + 1 == 255) begin
        xe = 8'd255; xm = 26'd0; xl = 3;
        return;
      end
      s = (s >> 1) | (s & 1);
      e = e + 1;
      xl = 4;
    end else begin
      p = 0;
      for (int i = 0; i < 26; i++) if (((s >> i) & 1) == 1) p = i;
      k = 25 - p;
      if (k > e - 1) k = e - 1;
      s = s << k;
      e = e - k;
      xl = 3 + k;
    end
    xm = s[25:0];
    xe = (s >= (64'd1 << 25)) ? 8'(e) : 8'd0;
  endfunction

  // ---- driver --------------------------------------------------------------
  task automatic run_txn(input string tag, input logic [7:0] ei,
                         input logic [25:0] a, input logic [25:0] b,
                         input logic sa, input logic sb, input logic xs,
                         input logic [7:0] xe, input logic [25:0] xm,
                         input int xl, input int hold);
    int cnt;
    bit got;
    @(posedge clk); #1;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    exp_in = ei; mant_a = a; mant_b = b; sign_a = sa; sign_b = sb;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 80) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      // Traffic while busy must be ignored
      in_valid = 1'($urandom_range(0, 1));
      exp_in = 8'($urandom); mant_a = 26'($urandom); mant_b = 26'($urandom);
      sign_a = 1'($urandom); sign_b = 1'($urandom);
      got = out_valid;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(cnt), 64'(xl));
    if (!got) return;
    check({tag, "_sign"}, 64'(out_sign), 64'(xs));
    check({tag, "_exp"}, 64'(out_exponent), 64'(xe));
    check({tag, "_mant"}, 64'(out_mantissa), 64'(xm));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {28'd0, out_valid, in_ready, out_sign,
                             out_exponent, out_mantissa},
            {28'd0, 1'b1, 1'b0, xs, xe, xm});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  // ---- directed vectors ----------------------------------------------------
  typedef struct {
    logic [7:0]  e;
    logic [25:0] a, b;
    logic        sa, sb;
    logic        xs;
    logic [7:0]  xe;
    logic [25:0] xm;
    int          xl;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        rs, ra_sa, ra_sb;
    logic [7:0]  re, rxe;
    logic [25:0] ra, rb, rxm;
    int          rxl, r;
    bit          seen;

    vecs[0] = '{8'd127, 26'h2000000, 26'h2000000, 1'b0, 1'b0, 1'b0, 8'd128, 26'h2000000, 4};
    vecs[1] = '{8'd127, 26'h3000000, 26'h3000000, 1'b0, 1'b1, 1'b0, 8'd0,   26'h0,       2};
    vecs[2] = '{8'd127, 26'h2000000, 26'h1000000, 1'b0, 1'b1, 1'b0, 8'd126, 26'h2000000, 4};
    vecs[3] = '{8'd254, 26'h3FFFFFC, 26'h3FFFFFC, 1'b0, 1'b0, 1'b0, 8'd255, 26'h0,       3};
    vecs[4] = '{8'd0,   26'h0800000, 26'h0800000, 1'b0, 1'b0, 1'b0, 8'd0,   26'h1000000, 3};
    vecs[5] = '{8'd255, 26'h0,       26'h0,       1'b0, 1'b1, 1'b0, 8'd255, 26'h1000000, 2};
    // Finite A against infinite B: sign comes from B
    vecs[6] = '{8'd255, 26'h2000000, 26'h0,       1'b0, 1'b1, 1'b1, 8'd255, 26'h0,       2};

    // ---- reset ----
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; exp_in = '0; mant_a = '0; mant_b = '0;
    #1;
    check("reset_state", {27'd0, out_valid, in_ready, out_sign, out_exponent,
                          out_mantissa}, {27'd0, 1'b0, 1'b1, 1'b0, 8'd0, 26'd0});
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // ---- directed ----
    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("dir%0d", i), vecs[i].e, vecs[i].a, vecs[i].b,
              vecs[i].sa, vecs[i].sb, vecs[i].xs, vecs[i].xe, vecs[i].xm,
              vecs[i].xl, (i == 0) ? 5 : 0);
    end

    // ---- randomized against model ----
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      re = 8'd255;
      else if (r == 1) re = 8'd0;
      else if (r == 2) re = 8'd254;
      else             re = 8'($urandom_range(1, 253));
      ra = 26'($urandom) >> $urandom_range(0, 25);
      if ($urandom_range(0, 3) == 0) rb = ra ^ 26'($urandom_range(0, 255));
      else                           rb = 26'($urandom) >> $urandom_range(0, 25);
      ra_sa = 1'($urandom);
      ra_sb = 1'($urandom);
      model(re, ra, rb, ra_sa, ra_sb, rs, rxe, rxm, rxl);
      run_txn($sformatf("rnd%0d", n), re, ra, rb, ra_sa, ra_sb, rs, rxe, rxm,
              rxl, $urandom_range(0, 2));
    end

    // ---- reset during normalization ----
    // Long left-normalization (S = 1) keeps the stage in NORM for many cycles
    // while the previous result still sits on the outputs.
    @(posedge clk); #1;
    in_valid = 1'b1;
    exp_in = 8'd127; mant_a = 26'h1; mant_b = 26'h0; sign_a = 1'b0; sign_b = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_outputs", {27'd0, out_valid, in_ready, out_sign, out_exponent,
                            out_mantissa}, {27'd0, 1'b0, 1'b1, 1'b0, 8'd0, 26'd0});
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_stale", 64'(seen), 64'd0);

    // Stage is usable again after the abort
    run_txn("post_reset", vecs[2].e, vecs[2].a, vecs[2].b, vecs[2].sa,
            vecs[2].sb, vecs[2].xs, vecs[2].xe, vecs[2].xm, vecs[2].xl, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
